// File: rtl/inst_fetch_unit.sv
// Purpose: instruction-fetch stage; on fetch_start captures pc, runs one req/rsp transaction to imem and latches the word into ir.
// Latency: fetch_start @T -> req @T+1 -> rsp @T+2 -> fetch_done/ir valid @T+3 at best; busy covers T+1..T+3.
// Backpressure: imem_req_valid is held until imem_req_ready; imem_rsp_ready is held in WAIT until imem_rsp_valid.
// Ports: clk/rst_n; pc, fetch_start, flush from the control side; imem_req_* / imem_rsp_* toward instruction
//        memory; ir, ir_addr, fetch_done, fetch_fault, busy toward decode and the controller.
module inst_fetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_start,
    input  logic              flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    output logic              imem_rsp_ready,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              fetch_done,
    output logic              fetch_fault,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t            state;
    logic              flushed;
    logic [ADDR_W-1:0] addr_q;

    // The request address comes from the captured copy so it never follows pc mid-transaction.
    assign imem_addr = addr_q;

    // All outputs are flops written alongside the state so they change only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flushed        <= 1'b0;
            addr_q         <= '0;
            ir             <= DATA_W'(RESET_IR);
            ir_addr        <= '0;
            imem_req_valid <= 1'b0;
            imem_rsp_ready <= 1'b0;
            fetch_done     <= 1'b0;
            fetch_fault    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            fetch_done  <= 1'b0;
            fetch_fault <= 1'b0;
            case (state)
                IDLE: begin
                    // A flush in the same cycle as a start cancels the start.
                    if (fetch_start && !flush) begin
                        addr_q <= pc;
                        busy   <= 1'b1;
                        if (pc[1:0] != 2'b00) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end else begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // A flush here cannot withdraw the request; remember it and drop the response later.
                    if (flush) begin
                        flushed <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        imem_rsp_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        imem_rsp_ready <= 1'b0;
                        // A flush arriving with the response still kills it.
                        if (flushed || flush) begin
                            flushed <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            ir         <= imem_rsp_data;
                            ir_addr    <= addr_q;
                            fetch_done <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (flush) begin
                        flushed <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is already committed; a flush now has nothing left to cancel.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    ir_addr <= addr_q;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    flushed        <= 1'b0;
                    imem_req_valid <= 1'b0;
                    imem_rsp_ready <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Purpose: self-checking bench for inst_fetch_unit with a simple memory responder and result model.
// Latency: drives and samples on the falling edge; every wait is a fixed-length loop.
// Backpressure: imem_req_ready / imem_rsp_valid delays are randomized per transaction.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        fetch_start;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic [31:0] ir;
    logic [31:0] ir_addr;
    logic        fetch_done;
    logic        fetch_fault;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_done = 0;

    // Model of the architecturally visible result registers.
    logic [31:0] exp_ir;
    logic [31:0] exp_ir_addr;

    inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_IR(32'h0000_0013)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .fetch_start    (fetch_start),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .ir             (ir),
        .ir_addr        (ir_addr),
        .fetch_done     (fetch_done),
        .fetch_fault    (fetch_fault),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (fetch_done) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_rsp_ready", imem_rsp_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", fetch_done, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_ir_addr", ir_addr, 0);
        check("rst_imem_addr", imem_addr, 0);
    endtask

    // fmode: 0 none, 1 flush in first REQ cycle, 2 flush in WAIT cycle fl_at (rsp_dly = response cycle).
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int req_dly,
                         input int rsp_dly, input int fmode, input int fl_at, input bit extra);
        bit discard;
        discard = (fmode != 0);
        pc = addr; fetch_start = 1'b1; flush = 1'b0;
        @(negedge clk);
        fetch_start = 1'b0;
        pc = $urandom;
        for (int i = 0; i <= req_dly; i++) begin
            check("req_valid", imem_req_valid, 1);
            check("req_addr", imem_addr, addr);
            check("busy_req", busy, 1);
            check("rsp_ready_req", imem_rsp_ready, 0);
            flush = (fmode == 1 && i == 0);
            imem_req_ready = (i == req_dly);
            @(negedge clk);
        end
        imem_req_ready = 1'b0; flush = 1'b0;
        for (int j = 0; j <= rsp_dly; j++) begin
            check("rsp_ready", imem_rsp_ready, 1);
            check("req_valid_wait", imem_req_valid, 0);
            check("busy_wait", busy, 1);
            flush = (fmode == 2 && j == fl_at);
            fetch_start = extra && (j == 0);
            imem_rsp_valid = (j == rsp_dly);
            imem_rsp_data = (j == rsp_dly) ? data : $urandom;
            @(negedge clk);
        end
        imem_rsp_valid = 1'b0; flush = 1'b0; fetch_start = 1'b0;
        if (!discard) begin
            exp_ir = data; exp_ir_addr = addr; exp_done++;
        end
        check("done", fetch_done, !discard);
        check("ir", ir, exp_ir);
        check("ir_addr", ir_addr, exp_ir_addr);
        check("rsp_ready_off", imem_rsp_ready, 0);
        check("req_valid_off", imem_req_valid, 0);
        if (!discard) begin
            check("busy_done", busy, 1);
            @(negedge clk);
            check("done_pulse_end", fetch_done, 0);
        end
        check("busy_idle", busy, 0);
    endtask

    task automatic fault(input logic [31:0] addr);
        pc = addr; fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check("fault_pulse", fetch_fault, 1);
        check("fault_req_valid", imem_req_valid, 0);
        check("fault_busy", busy, 1);
        @(negedge clk);
        exp_ir_addr = addr;
        check("fault_pulse_end", fetch_fault, 0);
        check("fault_req_valid2", imem_req_valid, 0);
        check("fault_busy_end", busy, 0);
        check("fault_ir_addr", ir_addr, exp_ir_addr);
        check("fault_ir", ir, exp_ir);
        check("fault_imem_addr", imem_addr, addr);
        check("fault_no_done", fetch_done, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int rd, sd, fm;
        rst_n = 1'b0; pc = '0; fetch_start = 1'b0; flush = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        exp_ir = 32'h0000_0013; exp_ir_addr = '0;
        @(negedge clk); @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        // Minimum-latency fetch, then stalled request/response.
        fetch(32'h0000_0000, 32'h0050_0093, 0, 0, 0, 0, 1'b0);
        fetch(32'h0000_0010, 32'h00B5_0533, 4, 2, 0, 0, 1'b0);
        // Flush in WAIT discards the response; the next fetch completes.
        fetch(32'h0000_0020, 32'hDEAD_BEEF, 0, 2, 2, 1, 1'b0);
        fetch(32'h0000_0040, 32'h0000_0013, 0, 0, 0, 0, 1'b0);
        // Flush on the very cycle the response arrives, and flush during REQ.
        fetch(32'h0000_0044, 32'h1111_2222, 1, 1, 2, 1, 1'b0);
        fetch(32'h0000_0048, 32'h3333_4444, 2, 0, 1, 0, 1'b0);
        // Misaligned address.
        fault(32'h0000_0006);
        // Second fetch_start during WAIT is ignored.
        fetch(32'h0000_0050, 32'h5555_6666, 0, 3, 0, 0, 1'b1);
        // fetch_start together with flush in IDLE issues nothing.
        pc = 32'h0000_0060; fetch_start = 1'b1; flush = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0; flush = 1'b0;
        check("start_flush_req", imem_req_valid, 0);
        check("start_flush_busy", busy, 0);
        @(negedge clk);
        check("start_flush_req2", imem_req_valid, 0);
        check("start_flush_ir_addr", ir_addr, exp_ir_addr);

        // Asynchronous reset while in REQ.
        pc = 32'h0000_0100; fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check("pre_rst_req_valid", imem_req_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_ir = 32'h0000_0013; exp_ir_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h0000_0104, 32'h0010_0113, 0, 0, 0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            a = {r[31:2], 2'b00};
            rd = $urandom_range(0, 3);
            sd = $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) begin
                a[1:0] = 2'($urandom_range(1, 3));
                fault(a);
            end else begin
                fm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                fetch(a, $urandom, rd, sd, fm, int'($urandom_range(0, sd)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        @(negedge clk);
        check("done_count", done_seen, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
